// File: rtl/llc_stall_tracker.sv
// llc_stall_tracker
// Stall/resume bookkeeping for the LLC input decoder: the reset/flush set
// sweep FSM with its set counter, the request-stall capture register, the
// parked-request valid flag and a sticky protocol error flag.
module llc_stall_tracker #(
    parameter int SET_BITS = 8,
    parameter int TAG_BITS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_rst,
    input  logic                start_flush,
    input  logic                incr_rst_flush_stalled_set,
    input  logic                clr_rst_stall,
    input  logic                clr_flush_stall,
    input  logic                set_req_stall,
    input  logic                clr_req_stall,
    input  logic [SET_BITS-1:0] stall_set,
    input  logic [TAG_BITS-1:0] stall_tag,
    input  logic                park_req,
    input  logic                clr_req_in_stalled_valid,
    output logic                rst_stall,
    output logic                flush_stall,
    output logic                req_stall,
    output logic [SET_BITS-1:0] rst_flush_stalled_set,
    output logic                req_in_stalled_valid,
    output logic [SET_BITS-1:0] req_in_stalled_set,
    output logic [TAG_BITS-1:0] req_in_stalled_tag,
    output logic                sweep_done,
    output logic                protocol_err
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RST_SWEEP   = 2'd1,
        FLUSH_SWEEP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [SET_BITS-1:0]   set_cnt_reg, set_cnt_next;
    logic                  sweep_done_reg, sweep_done_next;
    logic                  req_stall_reg, req_stall_next;
    logic [SET_BITS-1:0]   stalled_set_reg, stalled_set_next;
    logic [TAG_BITS-1:0]   stalled_tag_reg, stalled_tag_next;
    logic                  stalled_valid_reg, stalled_valid_next;
    logic                  protocol_err_reg, protocol_err_next;

    logic in_idle;
    logic start_taken;
    logic clr_taken;
    logic sweep_err;
    logic req_err;
    logic park_err;

    assign in_idle     = (state_reg == IDLE);
    assign start_taken = in_idle && (start_rst || start_flush);
    // Only the clear matching the active sweep ends it; the other is illegal.
    assign clr_taken   = ((state_reg == RST_SWEEP)   && clr_rst_stall) ||
                         ((state_reg == FLUSH_SWEEP) && clr_flush_stall);

    // Illegal sweep pulses are flagged and otherwise ignored.
    assign sweep_err = (in_idle && incr_rst_flush_stalled_set)
                     || (clr_rst_stall   && (state_reg != RST_SWEEP))
                     || (clr_flush_stall && (state_reg != FLUSH_SWEEP))
                     || (!in_idle && (start_rst || start_flush))
                     || (in_idle && start_rst && start_flush);
    assign req_err  = set_req_stall && req_stall_reg;
    assign park_err = park_req && stalled_valid_reg;

    // Sweep FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sweep FSM next-state logic; a reset sweep wins over a flush sweep.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_rst) begin
                    state_next = RST_SWEEP;
                end else if (start_flush) begin
                    state_next = FLUSH_SWEEP;
                end
            end
            RST_SWEEP: begin
                if (clr_rst_stall) begin
                    state_next = IDLE;
                end
            end
            FLUSH_SWEEP: begin
                if (clr_flush_stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep FSM outputs, decoded straight from the state register.
    always_comb begin
        rst_stall   = (state_reg == RST_SWEEP);
        flush_stall = (state_reg == FLUSH_SWEEP);
    end

    // Next values for the counter, request capture, park flag and error flag.
    always_comb begin
        set_cnt_next = set_cnt_reg;
        if (start_taken) begin
            set_cnt_next = '0;
        end else if (!in_idle && incr_rst_flush_stalled_set) begin
            // Natural wrap of the SET_BITS-wide adder gives modulo 2^SET_BITS.
            set_cnt_next = set_cnt_reg + SET_BITS'(1);
        end

        sweep_done_next = clr_taken;

        req_stall_next   = req_stall_reg;
        stalled_set_next = stalled_set_reg;
        stalled_tag_next = stalled_tag_reg;
        if (set_req_stall) begin
            req_stall_next   = 1'b1;
            stalled_set_next = stall_set;
            stalled_tag_next = stall_tag;
        end else if (clr_req_stall) begin
            req_stall_next = 1'b0;
        end

        stalled_valid_next = stalled_valid_reg;
        if (park_req) begin
            stalled_valid_next = 1'b1;
        end else if (clr_req_in_stalled_valid) begin
            stalled_valid_next = 1'b0;
        end

        protocol_err_next = protocol_err_reg || sweep_err || req_err || park_err;
    end

    // Datapath registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_cnt_reg       <= '0;
            sweep_done_reg    <= 1'b0;
            req_stall_reg     <= 1'b0;
            stalled_set_reg   <= '0;
            stalled_tag_reg   <= '0;
            stalled_valid_reg <= 1'b0;
            protocol_err_reg  <= 1'b0;
        end else begin
            set_cnt_reg       <= set_cnt_next;
            sweep_done_reg    <= sweep_done_next;
            req_stall_reg     <= req_stall_next;
            stalled_set_reg   <= stalled_set_next;
            stalled_tag_reg   <= stalled_tag_next;
            stalled_valid_reg <= stalled_valid_next;
            protocol_err_reg  <= protocol_err_next;
        end
    end

    assign rst_flush_stalled_set = set_cnt_reg;
    assign sweep_done            = sweep_done_reg;
    assign req_stall             = req_stall_reg;
    assign req_in_stalled_set    = stalled_set_reg;
    assign req_in_stalled_tag    = stalled_tag_reg;
    assign req_in_stalled_valid  = stalled_valid_reg;
    assign protocol_err          = protocol_err_reg;

endmodule

// File: tb/tb_llc_stall_tracker.sv
// Self-checking bench for llc_stall_tracker: directed scenarios followed by
// randomized pulses, all compared against a behavioural model.
module tb_llc_stall_tracker;

    localparam int SB = 8;
    localparam int TB = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_rst = 0, start_flush = 0, incr = 0;
    logic          clr_rst = 0, clr_flush = 0;
    logic          set_req = 0, clr_req = 0, park = 0, clr_valid = 0;
    logic [SB-1:0] stall_set = '0;
    logic [TB-1:0] stall_tag = '0;

    logic          rst_stall, flush_stall, req_stall, valid, sweep_done, protocol_err;
    logic [SB-1:0] cnt, st_set;
    logic [TB-1:0] st_tag;

    llc_stall_tracker #(.SET_BITS(SB), .TAG_BITS(TB)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .start_rst                  (start_rst),
        .start_flush                (start_flush),
        .incr_rst_flush_stalled_set (incr),
        .clr_rst_stall              (clr_rst),
        .clr_flush_stall            (clr_flush),
        .set_req_stall              (set_req),
        .clr_req_stall              (clr_req),
        .stall_set                  (stall_set),
        .stall_tag                  (stall_tag),
        .park_req                   (park),
        .clr_req_in_stalled_valid   (clr_valid),
        .rst_stall                  (rst_stall),
        .flush_stall                (flush_stall),
        .req_stall                  (req_stall),
        .rst_flush_stalled_set      (cnt),
        .req_in_stalled_valid       (valid),
        .req_in_stalled_set         (st_set),
        .req_in_stalled_tag         (st_tag),
        .sweep_done                 (sweep_done),
        .protocol_err               (protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model: sweep mode as text-like int (0 none, 1 reset, 2 flush).
    int  m_mode, m_cnt, m_set, m_tag;
    bit  m_done, m_err, m_rs, m_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_set = 0; m_tag = 0;
        m_done = 0; m_err = 0; m_rs = 0; m_valid = 0;
    endtask

    // Apply one clock edge's worth of pulses to the model.
    task automatic model_step();
        int old_mode = m_mode;
        m_done = 0;
        if (old_mode == 0) begin
            if (incr || clr_rst || clr_flush) m_err = 1;
            if (start_rst && start_flush) m_err = 1;
            if (start_rst) begin m_mode = 1; m_cnt = 0; end
            else if (start_flush) begin m_mode = 2; m_cnt = 0; end
        end else begin
            if (start_rst || start_flush) m_err = 1;
            if (incr) m_cnt = (m_cnt + 1) % (1 << SB);
            if (old_mode == 1) begin
                if (clr_flush) m_err = 1;
                if (clr_rst) begin m_mode = 0; m_done = 1; end
            end else begin
                if (clr_rst) m_err = 1;
                if (clr_flush) begin m_mode = 0; m_done = 1; end
            end
        end
        if (set_req) begin
            if (m_rs) m_err = 1;
            m_rs = 1; m_set = int'(stall_set); m_tag = int'(stall_tag);
        end else if (clr_req) begin
            m_rs = 0;
        end
        if (park) begin
            if (m_valid) m_err = 1;
            m_valid = 1;
        end else if (clr_valid) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("rst_stall",   64'(rst_stall),    64'(m_mode == 1));
        check("flush_stall", 64'(flush_stall),  64'(m_mode == 2));
        check("counter",     64'(cnt),          64'(m_cnt));
        check("sweep_done",  64'(sweep_done),   64'(m_done));
        check("protocol_err",64'(protocol_err), 64'(m_err));
        check("req_stall",   64'(req_stall),    64'(m_rs));
        check("stalled_set", 64'(st_set),       64'(m_set));
        check("stalled_tag", 64'(st_tag),       64'(m_tag));
        check("valid",       64'(valid),        64'(m_valid));
    endtask

    task automatic clear_inputs();
        start_rst = 0; start_flush = 0; incr = 0; clr_rst = 0; clr_flush = 0;
        set_req = 0; clr_req = 0; park = 0; clr_valid = 0;
    endtask

    // One transaction: drive on the falling edge, check 1 time unit after rising edge.
    task automatic step(input logic i_srst, input logic i_sfl, input logic i_inc,
                        input logic i_crst, input logic i_cfl, input logic i_sreq,
                        input logic i_creq, input logic i_park, input logic i_cval,
                        input logic [SB-1:0] i_set, input logic [TB-1:0] i_tag);
        @(negedge clk);
        start_rst = i_srst; start_flush = i_sfl; incr = i_inc;
        clr_rst = i_crst; clr_flush = i_cfl; set_req = i_sreq; clr_req = i_creq;
        park = i_park; clr_valid = i_cval; stall_set = i_set; stall_tag = i_tag;
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        compare_all();
        $display("cyc=%0d in=%b%b%b%b%b%b%b%b%b set=%02h tag=%05h -> rs=%b fs=%b cnt=%02h done=%b err=%b rq=%b v=%b",
                 cyc, i_srst, i_sfl, i_inc, i_crst, i_cfl, i_sreq, i_creq, i_park, i_cval,
                 i_set, i_tag, rst_stall, flush_stall, cnt, sweep_done, protocol_err, req_stall, valid);
        clear_inputs();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        compare_all();
        #3;
        rst = 1'b1;

        // Reset sweep: start, 255 increments, then increment plus clear.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        check("sweep_start_rst_stall", 64'(rst_stall), 64'(1));
        check("sweep_start_cnt", 64'(cnt), 64'(0));
        for (int i = 0; i < 255; i++) begin
            step(0, 0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
            check("sweep_cnt_step", 64'(cnt), 64'(i + 1));
        end
        step(0, 0, 1, 1, 0, 0, 0, 0, 0, '0, '0);
        check("sweep_wrap_cnt", 64'(cnt), 64'(0));
        check("sweep_end_rst_stall", 64'(rst_stall), 64'(0));
        check("sweep_done_pulse", 64'(sweep_done), 64'(1));
        idle_step();
        check("sweep_done_once", 64'(sweep_done), 64'(0));
        check("sweep_no_err", 64'(protocol_err), 64'(0));

        // Start collision: reset sweep wins.
        apply_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        check("collide_rst_stall", 64'(rst_stall), 64'(1));
        check("collide_flush_stall", 64'(flush_stall), 64'(0));
        check("collide_err", 64'(protocol_err), 64'(1));

        // Request stall capture.
        apply_reset();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h3C, 20'h01234);
        check("req_set1", 64'(req_stall), 64'(1));
        check("req_set1_set", 64'(st_set), 64'h3C);
        check("req_set1_tag", 64'(st_tag), 64'h1234);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'hFF, 20'hFFFFF);
        check("req_clr", 64'(req_stall), 64'(0));
        check("req_clr_hold_set", 64'(st_set), 64'h3C);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h01, 20'h00005);
        check("req_both", 64'(req_stall), 64'(1));
        check("req_both_set", 64'(st_set), 64'h01);
        check("req_both_tag", 64'(st_tag), 64'h5);

        // Park / consume.
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, '0, '0);
        check("park_set", 64'(valid), 64'(1));
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0, '0);
        check("park_clr", 64'(valid), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, '0, '0);
        check("park_both", 64'(valid), 64'(1));
        check("park_no_err", 64'(protocol_err), 64'(0));

        // Asynchronous reset in the middle of a flush sweep at set 0x40.
        apply_reset();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
        check("flush_cnt_40", 64'(cnt), 64'h40);
        check("flush_active", 64'(flush_stall), 64'(1));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_flush_stall", 64'(flush_stall), 64'(0));
        check("async_cnt", 64'(cnt), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_step();
        check("after_async_idle", 64'({rst_stall, flush_stall}), 64'(0));

        // Illegal pulses.
        apply_reset();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
        check("incr_idle_err", 64'(protocol_err), 64'(1));
        check("incr_idle_cnt", 64'(cnt), 64'(0));
        check("incr_idle_state", 64'({rst_stall, flush_stall}), 64'(0));
        apply_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
        check("pre_illegal_err", 64'(protocol_err), 64'(0));
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, '0, '0);
        check("clr_flush_in_rst_err", 64'(protocol_err), 64'(1));
        check("clr_flush_in_rst_state", 64'(rst_stall), 64'(1));
        check("clr_flush_in_rst_cnt", 64'(cnt), 64'(1));
        check("clr_flush_in_rst_done", 64'(sweep_done), 64'(0));

        // Randomized pulses with periodic resets so the sticky error stays informative.
        for (int blk = 0; blk < 30; blk++) begin
            apply_reset();
            for (int k = 0; k < 50; k++) begin
                step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 1) == 0,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     SB'($urandom), TB'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
